// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Purpose: program-fetch channel between the instruction source and the
// McCoy pc_sequencer.
//
// Handshake: a word moves on a rising edge where inst_valid and inst_ready
// are both high. The source holds inst_valid and inst_data steady until that
// edge. The sequencer raises inst_ready only in FETCH, and inst_ready never
// depends combinationally on inst_valid.
//
// Signals:
//   inst_valid  source -> sequencer  inst_data holds a word
//   inst_data   source -> sequencer  instruction word (INST_W bits)
//   inst_ready  sequencer -> source  sequencer takes the word this cycle
//
// Modports:
//   master  instruction source (program memory / testbench driver)
//   slave   pc_sequencer
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int INST_W = 8
);
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic              inst_ready;

  modport master (
    output inst_valid,
    output inst_data,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst_data,
    output inst_ready
  );
endinterface : pc_sequencer_if

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose: multi-cycle control sequencer for the McCoy core. It holds the
// program counter and the instruction register. It fetches instructions over
// the prog channel and resolves jump-always / branch-if-x8-zero. It also
// issues the register write-back strobe. The schedule is
// IDLE -> FETCH -> EXEC -> WB, with run, single-step and halt control.
//
// Parameters:
//   PC_W    width of pc, x8 and the branch target
//   INST_W  instruction width
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high, overrides every other input
//   run      level, continuous execution while high
//   step     pulse, runs one instruction from IDLE when run is low
//   prog     fetch channel (slave modport): inst_valid/inst_data in,
//            inst_ready out
//   ja       decoder: unconditional jump, sampled in EXEC
//   bez      decoder: branch when x8 == 0, sampled in EXEC
//   halt     decoder: halt instruction, sampled in EXEC
//   x8       register x8 value for the bez test
//   alu_out  branch/jump target
//   pc       current instruction address
//   ir       instruction register
//   reg_we   register-file write enable, one cycle per completed non-halt
//            instruction
//   halted   high while in IDLE
//   state    FSM state for debug: IDLE=0, FETCH=1, EXEC=2, WB=3
//
// All outputs are Moore outputs taken from registered state. No input has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PC_W   = 6,
  parameter int INST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  pc_sequencer_if.slave     prog,
  input  logic              ja,
  input  logic              bez,
  input  logic              halt,
  input  logic [PC_W-1:0]   x8,
  input  logic [PC_W-1:0]   alu_out,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] ir,
  output logic              reg_we,
  output logic              halted,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic   [PC_W-1:0]   r_pc;
  logic   [INST_W-1:0] r_ir;
  logic   [PC_W-1:0]   r_next_pc;
  // Set by a halt instruction. While set, a high run level cannot restart
  // execution. run must drop for a cycle in IDLE before fetching resumes.
  logic                r_halt_flag;
  // Set when the current instruction was started by step. WB then returns to
  // IDLE even if run went high during the instruction.
  logic                r_step_mode;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic   [PC_W-1:0]   w_pc_nxt;
  logic   [INST_W-1:0] w_ir_nxt;
  logic   [PC_W-1:0]   w_next_pc_nxt;
  logic                w_halt_flag_nxt;
  logic                w_step_mode_nxt;

  logic                w_taken;
  logic   [PC_W-1:0]   w_pc_inc;
  logic                w_accept;

  // ja wins over bez. When ja is set, x8 does not matter.
  assign w_taken  = ja | (bez & (x8 == '0));
  // This wraps at 2^PC_W, so the address after the top address is 0.
  assign w_pc_inc = r_pc + PC_W'(1);
  // A transfer happens only in FETCH with a valid word. Reset takes priority
  // in the register block, so no word is captured in a reset cycle.
  assign w_accept = (r_state == S_FETCH) && prog.inst_valid;

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath-register update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_next_pc_nxt   = r_next_pc;
    w_halt_flag_nxt = r_halt_flag;
    w_step_mode_nxt = r_step_mode;

    unique case (r_state)
      S_IDLE: begin
        // A low run level in IDLE re-arms run after a halt.
        if (!run) begin
          w_halt_flag_nxt = 1'b0;
        end
        if (!r_halt_flag && run) begin
          w_state_nxt     = S_FETCH;
          w_step_mode_nxt = 1'b0;
        end else if (!run && step) begin
          w_state_nxt     = S_FETCH;
          w_step_mode_nxt = 1'b1;
        end
      end

      S_FETCH: begin
        // Wait here as long as needed. pc and ir hold while stalled.
        if (w_accept) begin
          w_ir_nxt    = prog.inst_data;
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (halt) begin
          // A halt skips write-back and leaves pc on the halt instruction.
          w_halt_flag_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_next_pc_nxt = w_taken ? alu_out : w_pc_inc;
          w_state_nxt   = S_WB;
        end
      end

      S_WB: begin
        w_pc_nxt = r_next_pc;
        // A run drop during the instruction takes effect here, once the
        // instruction has finished.
        if (run && !r_step_mode) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_next_pc   <= '0;
      r_halt_flag <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_next_pc   <= w_next_pc_nxt;
      r_halt_flag <= w_halt_flag_nxt;
      r_step_mode <= w_step_mode_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  assign prog.inst_ready = (r_state == S_FETCH);
  assign reg_we          = (r_state == S_WB);
  assign halted          = (r_state == S_IDLE);
  assign state           = r_state;
  assign pc              = r_pc;
  assign ir              = r_ir;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Inputs change 1 ns after a rising edge.
// Outputs are checked at that same point, so every check sees the state the
// previous edge produced. Each check sits inline in its scenario task, and
// every expected value below is worked out by hand.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int PC_W   = 6;
  localparam int INST_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus and observation
  logic              run, step, ja, bez, halt;
  logic [PC_W-1:0]   x8, alu_out;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] ir;
  logic              reg_we, halted;
  logic [1:0]        state;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer_if #(.INST_W(INST_W)) u_if ();

  pc_sequencer #(.PC_W(PC_W), .INST_W(INST_W)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .step    (step),
    .prog    (u_if.slave),
    .ja      (ja),
    .bez     (bez),
    .halt    (halt),
    .x8      (x8),
    .alu_out (alu_out),
    .pc      (pc),
    .ir      (ir),
    .reg_we  (reg_we),
    .halted  (halted),
    .state   (state)
  );

  // Advance one clock edge and settle 1 ns past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decoder();
    ja = 1'b0; bez = 1'b0; halt = 1'b0; x8 = 6'd0; alu_out = 6'd0;
  endtask

  // Reset held two cycles while FETCH sees a valid word: nothing is captured.
  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; clear_decoder();
    u_if.inst_valid = 1'b0; u_if.inst_data = 8'h00;
    cyc(); cyc();
    reset = 1'b0;
    run = 1'b1; u_if.inst_valid = 1'b1; u_if.inst_data = 8'hA5;
    cyc();
    n_cmp++; if (state !== ST_FETCH) begin n_err++; $display("FAIL reset_pre_fetch state=%0d exp=%0d", state, ST_FETCH); end
    reset = 1'b1;
    cyc(); cyc();
    n_cmp++; if (pc !== 6'd0) begin n_err++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    n_cmp++; if (ir !== 8'h00) begin n_err++; $display("FAIL reset_ir got=%0h exp=0", ir); end
    n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL reset_halted got=%b exp=1", halted); end
    n_cmp++; if (u_if.inst_ready !== 1'b0) begin n_err++; $display("FAIL reset_inst_ready got=%b exp=0", u_if.inst_ready); end
    n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
    reset = 1'b0; run = 1'b0;
    cyc();
  endtask

  // Straight-line code: pc 0,1,2,3,4 at one instruction per 3 cycles. run
  // drops during the last instruction, which still completes.
  task automatic test_straight_line();
    run = 1'b1; u_if.inst_valid = 1'b1; clear_decoder();
    cyc();
    n_cmp++; if (state !== ST_FETCH || u_if.inst_ready !== 1'b1) begin n_err++; $display("FAIL sl_first_fetch state=%0d ready=%b exp=1/1", state, u_if.inst_ready); end
    for (int i = 0; i < 4; i++) begin
      u_if.inst_data = 8'h10 + 8'(i);
      n_cmp++; if (pc !== 6'(i)) begin n_err++; $display("FAIL sl_fetch_pc%0d got=%0d exp=%0d", i, pc, i); end
      cyc();
      n_cmp++; if (state !== ST_EXEC || reg_we !== 1'b0) begin n_err++; $display("FAIL sl_exec%0d state=%0d we=%b exp=2/0", i, state, reg_we); end
      n_cmp++; if (ir !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL sl_ir%0d got=%0h exp=%0h", i, ir, 8'h10 + 8'(i)); end
      cyc();
      n_cmp++; if (state !== ST_WB || reg_we !== 1'b1 || pc !== 6'(i)) begin n_err++; $display("FAIL sl_wb%0d state=%0d we=%b pc=%0d exp=3/1/%0d", i, state, reg_we, pc, i); end
      cyc();
      n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL sl_we_drop%0d got=%b exp=0", i, reg_we); end
    end
    // In FETCH with pc=4, drop run. The instruction still completes.
    n_cmp++; if (state !== ST_FETCH || pc !== 6'd4) begin n_err++; $display("FAIL sl_pc4 state=%0d pc=%0d exp=1/4", state, pc); end
    run = 1'b0; u_if.inst_data = 8'h14;
    cyc(); cyc();
    n_cmp++; if (state !== ST_WB || reg_we !== 1'b1) begin n_err++; $display("FAIL sl_rundrop_wb state=%0d we=%b exp=3/1", state, reg_we); end
    cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'd5 || halted !== 1'b1) begin n_err++; $display("FAIL sl_rundrop_idle state=%0d pc=%0d halted=%b exp=0/5/1", state, pc, halted); end
  endtask

  // Jump to 63, then a not-taken instruction wraps pc to 0.
  task automatic test_wrap();
    run = 1'b1; u_if.inst_valid = 1'b1; u_if.inst_data = 8'h20;
    cyc(); cyc();                       // FETCH, EXEC
    ja = 1'b1; alu_out = 6'd63;
    cyc();                              // WB
    clear_decoder();
    cyc();                              // FETCH
    n_cmp++; if (pc !== 6'd63) begin n_err++; $display("FAIL wrap_jump63 got=%0d exp=63", pc); end
    alu_out = 6'd9;                     // target present but not taken
    cyc(); cyc(); cyc();
    n_cmp++; if (pc !== 6'd0 || state !== ST_FETCH) begin n_err++; $display("FAIL wrap_pc0 pc=%0d state=%0d exp=0/1", pc, state); end
    run = 1'b0; clear_decoder();
    cyc(); cyc(); cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'd1) begin n_err++; $display("FAIL wrap_idle state=%0d pc=%0d exp=0/1", state, pc); end
  endtask

  // bez taken, bez not taken, and ja winning over a not-taken bez.
  task automatic test_branches();
    run = 1'b1; u_if.inst_valid = 1'b1; u_if.inst_data = 8'h30;
    cyc(); cyc();
    bez = 1'b1; x8 = 6'd0; alu_out = 6'h2A;
    cyc(); clear_decoder(); cyc();
    n_cmp++; if (pc !== 6'h2A) begin n_err++; $display("FAIL br_bez_taken got=%0h exp=2a", pc); end
    cyc();
    bez = 1'b1; x8 = 6'd5; alu_out = 6'h3F;
    cyc(); clear_decoder(); cyc();
    n_cmp++; if (pc !== 6'h2B) begin n_err++; $display("FAIL br_bez_not_taken got=%0h exp=2b", pc); end
    cyc();
    ja = 1'b1; bez = 1'b1; x8 = 6'd5; alu_out = 6'h10;
    cyc(); clear_decoder(); cyc();
    n_cmp++; if (pc !== 6'h10) begin n_err++; $display("FAIL br_ja_priority got=%0h exp=10", pc); end
    run = 1'b0;
    cyc(); cyc(); cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'h11) begin n_err++; $display("FAIL br_idle state=%0d pc=%0h exp=0/11", state, pc); end
  endtask

  // inst_valid held low for 4 FETCH cycles, which stretches the instruction
  // to 7 cycles.
  task automatic test_fetch_stall();
    run = 1'b1; u_if.inst_valid = 1'b0; u_if.inst_data = 8'hEE;
    cyc();                              // FETCH cycle 1
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (state !== ST_FETCH || u_if.inst_ready !== 1'b1) begin n_err++; $display("FAIL stall_fetch%0d state=%0d ready=%b exp=1/1", i, state, u_if.inst_ready); end
      n_cmp++; if (pc !== 6'h11 || ir !== 8'h30) begin n_err++; $display("FAIL stall_hold%0d pc=%0h ir=%0h exp=11/30", i, pc, ir); end
      cyc();
    end
    // FETCH cycle 5: the word is now valid.
    n_cmp++; if (state !== ST_FETCH) begin n_err++; $display("FAIL stall_cycle5 state=%0d exp=1", state); end
    u_if.inst_valid = 1'b1; u_if.inst_data = 8'h5C;
    cyc();                              // cycle 6 EXEC
    n_cmp++; if (state !== ST_EXEC || ir !== 8'h5C) begin n_err++; $display("FAIL stall_exec state=%0d ir=%0h exp=2/5c", state, ir); end
    run = 1'b0;
    cyc();                              // cycle 7 WB
    n_cmp++; if (state !== ST_WB || reg_we !== 1'b1) begin n_err++; $display("FAIL stall_wb state=%0d we=%b exp=3/1", state, reg_we); end
    cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'h12) begin n_err++; $display("FAIL stall_done state=%0d pc=%0h exp=0/12", state, pc); end
  endtask

  // A halt at pc=7 with run high. run must drop for a cycle before restart.
  task automatic test_halt();
    run = 1'b1; u_if.inst_valid = 1'b1; u_if.inst_data = 8'h40;
    cyc(); cyc();
    ja = 1'b1; alu_out = 6'd7;
    cyc(); clear_decoder(); cyc();
    n_cmp++; if (pc !== 6'd7) begin n_err++; $display("FAIL halt_setup_pc got=%0d exp=7", pc); end
    u_if.inst_data = 8'hFF;
    cyc();                              // EXEC
    halt = 1'b1; ja = 1'b1; alu_out = 6'h20;
    cyc();
    clear_decoder();
    n_cmp++; if (state !== ST_IDLE || reg_we !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_idle state=%0d we=%b halted=%b exp=0/0/1", state, reg_we, halted); end
    n_cmp++; if (pc !== 6'd7) begin n_err++; $display("FAIL halt_pc got=%0d exp=7", pc); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL halt_hold%0d state=%0d exp=0", i, state); end
    end
    run = 1'b0;
    cyc();
    run = 1'b1;
    cyc();
    n_cmp++; if (state !== ST_FETCH || pc !== 6'd7) begin n_err++; $display("FAIL halt_resume state=%0d pc=%0d exp=1/7", state, pc); end
    run = 1'b0;
    cyc(); cyc();
    n_cmp++; if (reg_we !== 1'b1) begin n_err++; $display("FAIL halt_resume_we got=%b exp=1", reg_we); end
    cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'd8) begin n_err++; $display("FAIL halt_resume_done state=%0d pc=%0d exp=0/8", state, pc); end
  endtask

  // One step pulse runs exactly one instruction. A step pulse during EXEC is
  // ignored and not queued.
  task automatic test_single_step();
    run = 1'b0; u_if.inst_valid = 1'b1; u_if.inst_data = 8'h77; clear_decoder();
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++; if (state !== ST_FETCH) begin n_err++; $display("FAIL step_fetch state=%0d exp=1", state); end
    cyc();
    n_cmp++; if (state !== ST_EXEC || ir !== 8'h77) begin n_err++; $display("FAIL step_exec state=%0d ir=%0h exp=2/77", state, ir); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++; if (state !== ST_WB || reg_we !== 1'b1) begin n_err++; $display("FAIL step_wb state=%0d we=%b exp=3/1", state, reg_we); end
    cyc();
    n_cmp++; if (state !== ST_IDLE || pc !== 6'd9) begin n_err++; $display("FAIL step_idle state=%0d pc=%0d exp=0/9", state, pc); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if (state !== ST_IDLE || pc !== 6'd9) begin n_err++; $display("FAIL step_not_queued%0d state=%0d pc=%0d exp=0/9", i, state, pc); end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_wrap();
    test_branches();
    test_fetch_stall();
    test_halt();
    test_single_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_sequencer
